// File: rtl/swap_responder.sv
// Register file with one external write port and a registered read port, plus an
// internal sequencer that exchanges two words on request (read A, read B, write A, write B).
module swap_responder #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] address_w,
    input  logic [DATA_WIDTH-1:0] data_w,
    input  logic [ADDR_WIDTH-1:0] address_r,
    output logic [DATA_WIDTH-1:0] data_r,
    input  logic                  swap_req,
    input  logic [ADDR_WIDTH-1:0] address_A,
    input  logic [ADDR_WIDTH-1:0] address_B,
    output logic                  swap_ack,
    output logic                  busy,
    output logic                  done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ_A  = 3'd1,
        READ_B  = 3'd2,
        WRITE_A = 3'd3,
        WRITE_B = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   data_r_q;
    logic [ADDR_WIDTH-1:0]   addr_a_q, addr_b_q;
    logic [DATA_WIDTH-1:0]   tmp_a_q, tmp_b_q;

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;

    always_comb begin
        state_d  = state_q;
        busy     = 1'b1;
        done     = 1'b0;
        swap_ack = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (swap_req) begin
                    swap_ack = 1'b1;
                    state_d  = READ_A;
                end
            end
            READ_A:  state_d = READ_B;
            READ_B:  state_d = WRITE_A;
            WRITE_A: state_d = WRITE_B;
            WRITE_B: state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Single array write port shared between the external writer (IDLE only) and the sequencer.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = address_w;
        wr_data = data_w;
        case (state_q)
            IDLE:    wr_en = we;
            WRITE_A: begin
                wr_en   = 1'b1;
                wr_addr = addr_a_q;
                wr_data = tmp_b_q;
            end
            WRITE_B: begin
                wr_en   = 1'b1;
                wr_addr = addr_b_q;
                wr_data = tmp_a_q;
            end
            default: wr_en = 1'b0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mem_q[gi] <= '0;
                end else if (wr_en && (wr_addr == ADDR_WIDTH'(gi))) begin
                    mem_q[gi] <= wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            data_r_q <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tmp_a_q  <= '0;
            tmp_b_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    // Read sees the pre-write word; operands latch only on acceptance.
                    data_r_q <= mem_q[address_r];
                    if (swap_req) begin
                        addr_a_q <= address_A;
                        addr_b_q <= address_B;
                    end
                end
                READ_A:  tmp_a_q <= mem_q[addr_a_q];
                READ_B:  tmp_b_q <= mem_q[addr_b_q];
                default: ;
            endcase
        end
    end

    assign data_r = data_r_q;

endmodule

// File: tb/tb_swap_responder.sv
// Self-checking bench for swap_responder: directed scenarios plus random operations
// compared against a word-array reference model.
module tb_swap_responder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       we;
    logic [6:0] address_w;
    logic [7:0] data_w;
    logic [6:0] address_r;
    logic [7:0] data_r;
    logic       swap_req;
    logic [6:0] address_A;
    logic [6:0] address_B;
    logic       swap_ack;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m [128];

    swap_responder #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (we),
        .address_w (address_w),
        .data_w    (data_w),
        .address_r (address_r),
        .data_r    (data_r),
        .swap_req  (swap_req),
        .address_A (address_A),
        .address_B (address_B),
        .swap_ack  (swap_ack),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 128; i++) m[i] = 8'h00;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        we = 1'b1; address_w = a; data_w = d; swap_req = 1'b0;
        m[a] = d;
        $display("write  addr=%0d data=0x%02h", a, d);
    endtask

    task automatic read_check(input logic [6:0] a, input string tag);
        @(negedge clk);
        we = 1'b0; swap_req = 1'b0; address_r = a;
        @(negedge clk);
        checks++;
        if (data_r !== m[a]) begin
            failures++;
            $display("FAIL %s read addr=%0d: data_r=0x%02h required 0x%02h", tag, a, data_r, m[a]);
        end else begin
            $display("read   addr=%0d data=0x%02h", a, data_r);
        end
    endtask

    // Issues a request in an IDLE cycle (optionally with a same-cycle external write), then
    // walks the five busy cycles. With hold=1 the initiator keeps swap_req high and keeps
    // writing 0xFF@20 throughout, both of which must be ignored.
    task automatic run_swap(input logic [6:0] a, input logic [6:0] b, input bit hold,
                            input bit wen, input logic [6:0] wa, input logic [7:0] wd,
                            input logic [6:0] ra, input string tag);
        logic [7:0] held;
        logic [7:0] t;
        logic       exp_done;
        @(negedge clk);
        swap_req = 1'b1; address_A = a; address_B = b; address_r = ra;
        we = wen; address_w = wa; data_w = wd;
        #1;
        checks++;
        if (swap_ack !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: ack=%b busy=%b required ack=1 busy=0", tag, swap_ack, busy);
        end
        held = m[ra];
        if (wen) m[wa] = wd;
        t = m[a]; m[a] = m[b]; m[b] = t;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            address_A = 7'($urandom); address_B = 7'($urandom); address_r = 7'($urandom);
            swap_req = hold; we = hold; address_w = 7'd20; data_w = 8'hFF;
            #1;
            exp_done = (k == 5);
            checks++;
            if (busy !== 1'b1 || done !== exp_done || swap_ack !== 1'b0 || data_r !== held) begin
                failures++;
                $display("FAIL %s busy cycle %0d: busy=%b done=%b ack=%b data_r=0x%02h required busy=1 done=%b ack=0 data_r=0x%02h",
                         tag, k, busy, done, swap_ack, data_r, exp_done, held);
            end
        end
        $display("swap   A=%0d B=%0d hold=%0d wen=%0d -> mem[A]=0x%02h mem[B]=0x%02h", a, b, hold, wen, m[a], m[b]);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; we = 1'b0; swap_req = 1'b0;
        address_w = '0; data_w = '0; address_r = 7'd3; address_A = '0; address_B = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || swap_ack !== 1'b0 || data_r !== 8'h00) begin
            failures++;
            $display("FAIL reset outputs: busy=%b done=%b ack=%b data_r=0x%02h required 0 0 0 0x00", busy, done, swap_ack, data_r);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        $display("reset  released");
        read_check(7'd3, "reset_mem");
        read_check(7'd127, "reset_mem");
    endtask

    task automatic test_write_read();
        do_write(7'd3, 8'h11);
        do_write(7'd9, 8'h22);
        read_check(7'd3, "wr_rd");
        read_check(7'd9, "wr_rd");
    endtask

    task automatic test_swap();
        run_swap(7'd3, 7'd9, 1'b0, 1'b0, 7'd0, 8'h00, 7'd3, "swap");
        read_check(7'd3, "swap");
        read_check(7'd9, "swap");
    endtask

    task automatic test_busy_ignore();
        do_write(7'd30, 8'hA1);
        do_write(7'd40, 8'hB2);
        do_write(7'd41, 8'hC3);
        do_write(7'd42, 8'hD4);
        run_swap(7'd30, 7'd40, 1'b1, 1'b0, 7'd0, 8'h00, 7'd30, "busy_ign");
        // Request still held: must be accepted in the very first IDLE cycle after DONE.
        run_swap(7'd41, 7'd42, 1'b0, 1'b0, 7'd0, 8'h00, 7'd41, "back_to_back");
        read_check(7'd20, "dropped_write");
        read_check(7'd30, "busy_ign");
        read_check(7'd42, "back_to_back");
    endtask

    task automatic test_simul_write_swap();
        run_swap(7'd3, 7'd9, 1'b0, 1'b1, 7'd3, 8'h55, 7'd9, "simul");
        read_check(7'd9, "simul");
        read_check(7'd3, "simul");
    endtask

    task automatic test_same_addr();
        do_write(7'd5, 8'h7E);
        run_swap(7'd5, 7'd5, 1'b0, 1'b0, 7'd0, 8'h00, 7'd5, "same_addr");
        read_check(7'd5, "same_addr");
    endtask

    task automatic test_reset_mid_swap();
        @(negedge clk);
        we = 1'b0; swap_req = 1'b1; address_A = 7'd3; address_B = 7'd9;
        #1;
        checks++;
        if (swap_ack !== 1'b1) begin
            failures++;
            $display("FAIL midrst accept: ack=%b required 1", swap_ack);
        end
        @(negedge clk); swap_req = 1'b0;   // READ_A
        @(negedge clk);                    // READ_B
        @(negedge clk);                    // WRITE_A
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || swap_ack !== 1'b0 || data_r !== 8'h00) begin
            failures++;
            $display("FAIL midrst outputs: busy=%b done=%b ack=%b data_r=0x%02h required 0 0 0 0x00", busy, done, swap_ack, data_r);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL midrst after cycle %0d: busy=%b done=%b required 0 0", k, busy, done);
            end
        end
        $display("reset  mid-swap done");
        read_check(7'd3, "midrst_mem");
        read_check(7'd9, "midrst_mem");
        read_check(7'd5, "midrst_mem");
        read_check(7'd30, "midrst_mem");
    endtask

    task automatic test_random();
        logic [6:0] a, b;
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 2))
                0: do_write(7'($urandom), 8'($urandom));
                1: read_check(7'($urandom), "rand_read");
                default: begin
                    a = 7'($urandom);
                    b = ($urandom_range(0, 3) == 0) ? a : 7'($urandom);
                    run_swap(a, b, 1'($urandom), 1'($urandom), 7'($urandom), 8'($urandom),
                             7'($urandom), "rand_swap");
                end
            endcase
        end
        for (int i = 0; i < 128; i++) read_check(7'(i), "final_sweep");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_swap();
        test_busy_ignore();
        test_simul_write_swap();
        test_same_addr();
        test_reset_mid_swap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
